// File: rtl/fifo_chk_pkg.sv
// Shared types and defaults for the FIFO read-side pattern checker.
// The FSM state encoding is used by fifo_rd_checker.
package fifo_chk_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Used for the word and error tallies of the read checker.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_checker.sv
// Drains the async FIFO read port and checks it against an incrementing
// byte pattern, reporting word/error counts and first-error details.
module fifo_rd_checker
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             rd_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_words,
    input  logic             rd_empty,
    input  logic [WIDTH-1:0] rd_data,
    output logic             rd_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic [WIDTH-1:0] expected;
    logic [CNT_W-1:0] wc_next;
    logic             clr;
    logic             mism;

    assign busy  = (state == ST_ALIGN) || (state == ST_CHECK);
    assign done  = (state == ST_DONE);
    assign pass  = done && (err_cnt == '0);
    assign rd_en = busy && !rd_empty && !stop;
    assign clr   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mism  = (state == ST_CHECK) && rd_en && (rd_data != expected);

    // Count as it will read after this pop, saturation included.
    assign wc_next = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk     (rd_clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (rd_en),
        .cnt     (word_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (rd_clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (mism),
        .cnt     (err_cnt)
    );

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            num_lat       <= '0;
            expected      <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clr) begin
            num_lat       <= num_words;
            expected      <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (rd_en) begin
            // Resync on every pop so a dropped word costs one error.
            expected <= rd_data + WIDTH'(1);
            if (mism && (err_cnt == '0)) begin
                first_err_idx <= word_cnt;
                first_err_exp <= expected;
                first_err_got <= rd_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (stop) begin
                    state_nxt = ST_DONE;
                end else if (rd_en) begin
                    state_nxt = (num_lat == CNT_W'(1)) ? ST_DONE : ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (stop) begin
                    state_nxt = ST_DONE;
                end else if (rd_en && (num_lat != '0) && (wc_next == num_lat)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) state_nxt = ST_ALIGN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Randomised bench for fifo_rd_checker against a queue-based model of
// the popped stream; counts and first-error data are derived by scanning it.
module tb_fifo_rd_checker;

    logic        rd_clk = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic        stop = 0;
    logic [15:0] num_words = 0;
    logic        rd_empty = 1;
    logic [7:0]  rd_data = 0;
    logic        rd_en;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_got;

    fifo_rd_checker #(.WIDTH(8), .CNT_W(16)) dut (
        .rd_clk        (rd_clk),
        .reset_n       (reset_n),
        .start         (start),
        .stop          (stop),
        .num_words     (num_words),
        .rd_empty      (rd_empty),
        .rd_data       (rd_data),
        .rd_en         (rd_en),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .word_cnt      (word_cnt),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    always #5 rd_clk = ~rd_clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] fq[$];
    logic [7:0] popped[$];
    bit         m_busy = 0;
    bit         m_done = 0;
    int         m_num = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        int         err;
        int         fidx;
        logic [7:0] fexp;
        logic [7:0] fgot;
        logic [7:0] e;
        err = 0; fidx = 0; fexp = 0; fgot = 0;
        for (int i = 1; i < popped.size(); i++) begin
            e = popped[i-1] + 8'd1;
            if (popped[i] != e) begin
                if (err == 0) begin
                    fidx = i; fexp = e; fgot = popped[i];
                end
                err++;
            end
        end
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("pass", pass, m_done && (err == 0));
        chk("word_cnt", word_cnt, popped.size());
        chk("err_cnt", err_cnt, err);
        chk("first_err_idx", first_err_idx, fidx);
        chk("first_err_exp", first_err_exp, fexp);
        chk("first_err_got", first_err_got, fgot);
    endtask

    task automatic cyc(input bit st, input bit sp, input bit stall);
        bit en;
        @(negedge rd_clk);
        start = st;
        stop = sp;
        rd_empty = stall || (fq.size() == 0);
        rd_data = (fq.size() != 0) ? fq[0] : 8'($urandom);
        #1;
        en = m_busy && !rd_empty && !sp;
        chk("rd_en", rd_en, en);
        @(posedge rd_clk);
        #1;
        if (m_busy) begin
            if (sp) begin
                m_busy = 0; m_done = 1;
            end else if (en) begin
                popped.push_back(fq.pop_front());
                if (m_num != 0 && popped.size() == m_num) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end else if (st) begin
            popped.delete();
            m_num = num_words;
            m_busy = 1;
            m_done = 0;
        end
        start = 0;
        stop = 0;
        check_outs();
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    endtask

    task automatic run(input int num, input int max_cyc, input int stall_at,
                       input int stall_len, input int stop_at, input bit rnd);
        int k;
        num_words = 16'(num);
        cyc(1, rnd ? 1'($urandom % 2) : 1'b0, 0);
        num_words = 16'($urandom);
        k = 0;
        while (!m_done && k < max_cyc) begin
            if (rnd)
                cyc(0, ($urandom % 40) == 0, ($urandom % 5) == 0);
            else
                cyc(0, k == stop_at,
                    (k >= stall_at) && (k < stall_at + stall_len));
            k++;
        end
        if (!m_done) chk("run_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] v;
        int         n;

        repeat (2) @(negedge rd_clk);
        chk("rst_rd_en", rd_en, 0);
        check_outs();
        @(negedge rd_clk);
        reset_n = 1;

        // Clean run
        fill(8'h00, 20);
        run(20, 100, -1, 0, -1, 0);
        chk("clean_word_cnt", word_cnt, 20);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_pass", pass, 1);

        // Dropped word
        fq.delete();
        fq.push_back(8'h05); fq.push_back(8'h06);
        fq.push_back(8'h08); fq.push_back(8'h09);
        run(4, 50, -1, 0, -1, 0);
        chk("drop_err_cnt", err_cnt, 1);
        chk("drop_idx", first_err_idx, 2);
        chk("drop_exp", first_err_exp, 8'h07);
        chk("drop_got", first_err_got, 8'h08);
        chk("drop_pass", pass, 0);

        // Wrap
        fill(8'hFE, 4);
        run(4, 50, -1, 0, -1, 0);
        chk("wrap_err_cnt", err_cnt, 0);
        chk("wrap_pass", pass, 1);

        // Empty stall mid-run
        fill(8'h30, 10);
        run(10, 60, 4, 5, -1, 0);
        chk("stall_word_cnt", word_cnt, 10);
        chk("stall_pass", pass, 1);

        // Unlimited mode ended by stop, one word left behind
        fill(8'h00, 301);
        run(0, 400, -1, 0, 300, 0);
        chk("unlim_word_cnt", word_cnt, 300);
        chk("unlim_left", fq.size(), 1);
        chk("unlim_done", done, 1);

        // Reset mid-run
        fill(8'h00, 10);
        num_words = 10;
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        @(negedge rd_clk);
        rd_empty = 0;
        rd_data = fq[0];
        #2;
        reset_n = 0;
        #1;
        popped.delete();
        m_busy = 0;
        m_done = 0;
        chk("rst_mid_rd_en", rd_en, 0);
        check_outs();
        @(negedge rd_clk);
        reset_n = 1;

        // Restart; a second start while busy must not relatch num_words
        fill(8'h40, 8);
        num_words = 8;
        cyc(1, 0, 0);
        num_words = 3;
        cyc(1, 0, 0);
        n = 0;
        while (!m_done && n < 40) begin
            cyc(0, 0, 0);
            n++;
        end
        chk("restart_word_cnt", word_cnt, 8);
        chk("restart_pass", pass, 1);

        // Randomised runs with corrupted streams, stalls and stops
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 25);
            fq.delete();
            v = 8'($urandom);
            for (int i = 0; i < n + 5; i++) begin
                fq.push_back(v);
                case ($urandom % 10)
                    0: v = v + 8'd2;
                    1: v = 8'($urandom);
                    default: v = v + 8'd1;
                endcase
            end
            run(n, 400, -1, 0, -1, 1);
            repeat (2) cyc(0, 1'($urandom % 2), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
